int_controller: RTL and testbench

//  Upstream of the processor top: collects NUM_IRQ external request lines and drives its single-bit

---
 rtl/int_controller.sv | 149 ++++++++++++++
 tb/tb_int_controller.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/int_controller.sv
// int_controller: edge-latched, masked, lowest-index-first interrupt sequencer for the processor top.
// Optional macro IRQ_SYNC_EN inserts a 2-flop synchronizer on every irq_in bit ahead of edge detection.
module int_controller #(
  parameter int NUM_IRQ = 4,
  parameter int IDW     = 2,
  parameter int HOLDOFF = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               stall,
  input  logic               iack,
  output logic               interrupt,
  output logic [IDW-1:0]     irq_id,
  output logic [NUM_IRQ-1:0] pending,
  output logic               busy
);

  localparam int CNTW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FIRE,
    S_SERVICE,
    S_HOLD
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [NUM_IRQ-1:0] r_hist;
  logic [NUM_IRQ-1:0] r_pending;
  logic [NUM_IRQ-1:0] r_mask;
  logic [NUM_IRQ-1:0] w_irq_s;
  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_elig;
  logic [NUM_IRQ-1:0] w_clr;
  logic [IDW-1:0]     r_irq_id;
  logic [IDW-1:0]     w_win;
  logic [CNTW-1:0]    r_cnt;
  logic [CNTW-1:0]    w_cnt_next;
  logic               r_interrupt;
  logic               r_busy;
  logic               w_launch;
  logic               w_ack;

`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] r_sync1;
  logic [NUM_IRQ-1:0] r_sync2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= irq_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_irq_s = r_sync2;
`else
  assign w_irq_s = irq_in;
`endif

  assign w_rise = w_irq_s & ~r_hist;
  assign w_elig = r_pending & r_mask;

  // Scan from the top so the lowest eligible index is the last write and wins.
  always_comb begin
    w_win = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_elig[i]) w_win = IDW'(i);
    end
  end

  assign w_launch = (r_state == S_IDLE) && (|w_elig) && !stall;
  assign w_ack    = (r_state == S_SERVICE) && iack;
  assign w_clr    = w_ack ? (NUM_IRQ'(1) << r_irq_id) : '0;

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_launch) w_next = S_FIRE;
      end
      S_FIRE: begin
        w_next = S_SERVICE;
      end
      S_SERVICE: begin
        if (iack) begin
          w_next     = S_HOLD;
          w_cnt_next = CNTW'(HOLDOFF - 1);
        end
      end
      S_HOLD: begin
        if (r_cnt == '0) w_next = S_IDLE;
        else             w_cnt_next = r_cnt - CNTW'(1);
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // A new edge on the bit being acknowledged wins over the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hist    <= '0;
      r_pending <= '0;
      r_mask    <= '0;
    end else begin
      r_hist    <= w_irq_s;
      r_pending <= (r_pending & ~w_clr) | w_rise;
      if (mask_we) r_mask <= mask_wdata;
    end
  end

  // Outputs are flops fed from the next-state decode so they never glitch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_irq_id    <= '0;
      r_interrupt <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      if (w_launch) r_irq_id <= w_win;
      r_interrupt <= (w_next == S_FIRE);
      r_busy      <= (w_next != S_IDLE);
    end
  end

  assign interrupt = r_interrupt;
  assign irq_id    = r_irq_id;
  assign pending   = r_pending;
  assign busy      = r_busy;

endmodule

// File: tb/tb_int_controller.sv
// Bench for int_controller: directed scenarios plus randomized traffic against a behavioural model.
// Honours IRQ_SYNC_EN so the model's input latency follows the DUT build.
module tb_int_controller;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int H   = 4;
`ifdef IRQ_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   irq_in = '0;
  logic           mask_we = 1'b0;
  logic [N-1:0]   mask_wdata = '0;
  logic           stall = 1'b0;
  logic           iack = 1'b0;
  logic           interrupt;
  logic [IDW-1:0] irq_id;
  logic [N-1:0]   pending;
  logic           busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_pulse = -1;

  // behavioural model state
  logic [N-1:0]   m_pend, m_mask, m_hist;
  logic [N-1:0]   m_dl[$];
  logic [IDW-1:0] m_id;
  logic           m_int, m_await, m_busy;
  int             m_hold;

  int_controller #(.NUM_IRQ(N), .IDW(IDW), .HOLDOFF(H)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .stall      (stall),
    .iack       (iack),
    .interrupt  (interrupt),
    .irq_id     (irq_id),
    .pending    (pending),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_pend = '0; m_mask = '0; m_hist = '0; m_id = '0;
    m_int = 1'b0; m_await = 1'b0; m_busy = 1'b0; m_hold = 0;
    m_dl.delete();
    for (int i = 0; i < LAT; i++) m_dl.push_back('0);
    last_pulse = -1;
  endtask

  // One controller cycle: a pulse is followed by waiting for iack, then H quiet cycles.
  task automatic model_step();
    logic [N-1:0] s, rise, elig, low, clr;
    s = irq_in;
    if (LAT > 0) begin
      s = m_dl.pop_front();
      m_dl.push_back(irq_in);
    end
    rise   = s & ~m_hist;
    m_hist = s;
    elig   = m_pend & m_mask;
    clr    = '0;
    if (m_hold > 0) begin
      m_hold--;
    end else if (m_await) begin
      if (iack) begin
        clr     = N'(1) << m_id;
        m_await = 1'b0;
        m_hold  = H;
      end
    end else if (m_int) begin
      m_int   = 1'b0;
      m_await = 1'b1;
    end else if (elig != '0 && !stall) begin
      low = elig & (~elig + N'(1));
      for (int b = 0; b < N; b++) if (low == (N'(1) << b)) m_id = IDW'(b);
      m_int = 1'b1;
    end
    m_pend = (m_pend & ~clr) | rise;
    if (mask_we) m_mask = mask_wdata;
    m_busy = m_int | m_await | (m_hold > 0);
  endtask

  task automatic check_outputs();
    check("interrupt", interrupt, m_int);
    check("busy", busy, m_busy);
    check("irq_id", irq_id, m_id);
    check("pending", pending, m_pend);
    if (interrupt) begin
      if (last_pulse >= 0) check("spacing_ok", (cyc - last_pulse) >= H + 2, 1);
      last_pulse = cyc;
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input logic [N-1:0] irq, input logic mwe, input logic [N-1:0] mwd,
                       input logic st, input logic ack);
    irq_in = irq; mask_we = mwe; mask_wdata = mwd; stall = st; iack = ack;
    @(posedge clk);
    if (reset) model_step();
    cyc++;
    #1 check_outputs();
    @(negedge clk);
  endtask

  // Asserts reset between clock edges and checks the outputs clear without an edge.
  task automatic async_reset(input int edges);
    #2 reset = 1'b0;
    #1;
    check("rst_interrupt", interrupt, 0);
    check("rst_busy", busy, 0);
    check("rst_pending", pending, 0);
    check("rst_irq_id", irq_id, 0);
    model_reset();
    @(negedge clk);
    for (int i = 0; i < edges; i++) cycle(N'($urandom), 1'b0, '0, 1'b0, 1'b0);
    reset = 1'b1;
  endtask

  initial begin
    int lat, n, np;
    int ids[2];
    logic got;
    logic [N-1:0] rnd_irq;

    // 1: reset with random request lines, then a masked-off request
    model_reset();
    #1 reset = 1'b0;
    #1;
    check("rst0_interrupt", interrupt, 0);
    check("rst0_busy", busy, 0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) cycle(N'($urandom), 1'b0, '0, 1'b0, 1'b0);
    reset = 1'b1;
    cycle(4'b0010, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < LAT + 2; i++) cycle(4'b0000, 1'b0, '0, 1'b0, 1'b0);
    check("t1_pending", pending, 4'b0010);

    // enable all lines; the leftover request on line 1 gets serviced
    cycle(4'b0000, 1'b1, 4'hF, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) cycle(4'b0000, 1'b0, '0, 1'b0, 1'b1);

    // 2: basic service with latency and holdoff length
    lat = 0;
    do begin
      cycle(4'b0100, 1'b0, '0, 1'b0, 1'b0);
      lat++;
    end while (!pending[2] && lat < 10);
    check("t2_latency", lat, LAT + 1);
    cycle(4'b0100, 1'b0, '0, 1'b0, 1'b0);
    check("t2_int", interrupt, 1);
    check("t2_id", irq_id, 2);
    cycle(4'b0100, 1'b0, '0, 1'b0, 1'b0);
    check("t2_int_once", interrupt, 0);
    cycle(4'b0100, 1'b0, '0, 1'b0, 1'b1);
    check("t2_pend_clr", pending, 0);
    n = 0;
    while (busy && n < 20) begin
      cycle(4'b0100, 1'b0, '0, 1'b0, 1'b0);
      n++;
    end
    check("t2_holdoff", n, H);

    // 3: simultaneous requests on lines 3 and 1
    ids[0] = -1; ids[1] = -1; np = 0;
    cycle(4'b1110, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 40 && np < 2; i++) begin
      cycle(4'b1110, 1'b0, '0, 1'b0, 1'b1);
      if (interrupt) begin
        ids[np] = int'(irq_id);
        np++;
      end
    end
    check("t3_first", ids[0], 1);
    check("t3_second", ids[1], 3);
    for (int i = 0; i < H + 4; i++) cycle(4'b1110, 1'b0, '0, 1'b0, 1'b1);

    // 4: stall holds off the launch
    np = 0;
    cycle(4'b1111, 1'b1, 4'b0001, 1'b1, 1'b0);
    np += int'(interrupt);
    for (int i = 0; i < 5; i++) begin
      cycle(4'b1111, 1'b0, '0, 1'b1, 1'b0);
      np += int'(interrupt);
    end
    check("t4_stalled", np, 0);
    cycle(4'b1111, 1'b0, '0, 1'b0, 1'b0);
    check("t4_int", interrupt, 1);
    check("t4_id", irq_id, 0);

    // 5: new edge coincides with iack on the serviced line
    for (int i = 0; i < LAT + 1; i++) cycle(4'b1110, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < LAT; i++) cycle(4'b1111, 1'b0, '0, 1'b0, 1'b0);
    cycle(4'b1111, 1'b0, '0, 1'b0, 1'b1);
    check("t5_pend0", pending[0], 1);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      cycle(4'b1111, 1'b0, '0, 1'b0, 1'b0);
      got = interrupt;
    end
    check("t5_pulse", got, 1);
    check("t5_id", irq_id, 0);

    // 6: asynchronous reset while in service
    cycle(4'b1111, 1'b0, '0, 1'b0, 1'b0);
    check("t6_busy_before", busy, 1);
    async_reset(2);

    // randomized traffic with occasional asynchronous resets
    rnd_irq = '0;
    for (int t = 0; t < 1500; t++) begin
      rnd_irq = rnd_irq ^ (N'($urandom) & N'($urandom) & N'($urandom));
      if ($urandom_range(0, 399) == 0) async_reset(1 + int'($urandom_range(0, 2)));
      else cycle(rnd_irq, $urandom_range(0, 15) == 0, N'($urandom),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
